mix_round_sequencer: RTL and testbench
======================================

// Module: mix_round_sequencer
// PURPOSE
//  Time-multiplexed controller for the 8-lane, 32-bit mixing datapath. One shared ALU slice
//  (mix_alu) replaces the fully unrolled per-clock chain. A round is 8 stages x 8 lanes,
//  executed as one lane-update per cycle, so one round takes 64 cycles.
//  Start/busy/done handshake; sits between a test/stimulus driver and any consumer of the state.
// PARAMETERS
//  ROUNDS  1   rounds executed per accepted start (>=1)
//  CNT_W   16  width of internal round counter; must satisfy ROUNDS < 2**CNT_W
// PORTS
//  clk        in   1    single clock; all state updates on posedge
//  rst        in   1    asynchronous, active-high reset
//  start      in   1    request ROUNDS rounds; sampled only in IDLE
//  init       in   1    reload seed state; sampled only in IDLE
//  busy       out  1    high in RUN
//  done       out  1    one-cycle pulse after the last lane update of the last round
//  state_out  out  256  live register file; lane i at [32*i +: 32]
// BEHAVIOUR
//  Reset (async, rst=1): lanes o[i]=i (0..7), FSM=IDLE, busy=0, done=0, stage=0, lane=0, rounds=0.
//  FSM: IDLE -start-> RUN; RUN -(stage 7, lane 7, last round)-> DONE; DONE -> IDLE (1 cycle, done=1).
//  In IDLE: init=1 reloads o[i]=i next edge. init and start both high: init wins, start dropped.
//  start/init while RUN or DONE: ignored (no queueing).
//  RUN: each cycle writes o[lane] = f(stage,lane) from the CURRENT register file. Lower lanes are
//  already updated (blocking semantics). Then lane++; at lane 7 wrap to 0 and stage++;
//  at stage 7 wrap to 0 and round++. All indices are mod 8; all arithmetic is mod 2**32, unsigned.
//   S0 o[i]+=i          S1 o[i]+=o[i-1]          S2 o[i]=o[i]+o[i+1]-o[i+5]
//   S3 o[i]^=o[i+3]<<16 S4 o[i]=o[i]-(o[i+2]>>17)+(o[i+4]>>12)
//   S5 o[i]=o[i]+o[i-1]-o[i-2]
//   S6 o[i]=o[i]*A[i]+B[i]  A={2,3,5,7,11,13,17,19}  B={3,5,7,11,13,17,19,23}
//   S7 o[i]=o[i]*C[i]+D[i]  C={2,3,3,3,5,13,35,87}   D={0,1,8,27,64,125,216,343}
//  Latency: start accepted at edge T. Busy is high from T+1. Last write occurs at edge T+64*ROUNDS.
//  done=1 and busy=0 during cycle T+64*ROUNDS .. +1. IDLE resumes after that.
//  State persists across starts: a second start continues mixing from the current values.
//  rst mid-RUN: immediate abort, seed restored, no done pulse.
// CONFIGURATION
//  MIX_ROUND_CNT_EN defined: adds output round_cnt_total [31:0].
//   It counts completed rounds (increments at each stage-7/lane-7 write) and wraps at 2**32.
//   It is cleared only by rst; init does not clear it.
//  MIX_ROUND_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  Package mix_pkg: LANES=8, STAGES=8, W=32; coefficient tables A,B,C,D; stage enum S0..S7;
//   FSM state enum IDLE/RUN/DONE.
//  Sub-module mix_alu (combinational): inputs stage, lane, o[lane], and three operand lanes
//   selected by the sequencer; output is the 32-bit result.
//  Sequencer owns the FSM, lane/stage/round counters, operand mux and 8x32 register file.
// TESTING
//  1 rst pulse -> state_out lanes = 0,1,...,7; busy=0; done=0.
//  2 start, ROUNDS=1 -> after 8 writes lanes = 0,2,4,6,8,10,12,14.
//    After 16 writes lanes = 14,16,20,26,34,44,56,70.
//  3 ROUNDS=1 start -> done pulses exactly once, 64 cycles after acceptance.
//    Final lanes match the golden sequential model (one unrolled round).
//  4 start pulsed during RUN and init in DONE -> ignored.
//    Then init+start together in IDLE -> lanes reload to 0..7, busy stays 0.
//  5 rst asserted mid-round (after 30 writes) -> asynchronous return to seed and IDLE.
//    No done pulse; a fresh start then matches test 3.
//  6 With MIX_ROUND_CNT_EN, ROUNDS=3, two starts -> round_cnt_total=6, lanes match 6 model rounds.
//    Build without the macro -> port absent, lanes are identical.

Source files
------------

// File: rtl/mix_pkg.sv
// Shared definitions for the 8-lane, 32-bit mixing datapath.
// Contents: geometry constants, stage and FSM enums, and per-lane multiply/add coefficient tables
// used by the S6 and S7 stages.
package mix_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned STAGES = 8;
    localparam int unsigned W      = 32;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } stage_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    localparam logic [W-1:0] COEF_A [LANES] = '{32'd2, 32'd3, 32'd5, 32'd7,
                                                32'd11, 32'd13, 32'd17, 32'd19};
    localparam logic [W-1:0] COEF_B [LANES] = '{32'd3, 32'd5, 32'd7, 32'd11,
                                                32'd13, 32'd17, 32'd19, 32'd23};
    localparam logic [W-1:0] COEF_C [LANES] = '{32'd2, 32'd3, 32'd3, 32'd3,
                                                32'd5, 32'd13, 32'd35, 32'd87};
    localparam logic [W-1:0] COEF_D [LANES] = '{32'd0, 32'd1, 32'd8, 32'd27,
                                                32'd64, 32'd125, 32'd216, 32'd343};

endpackage

// File: rtl/mix_alu.sv
// Combinational lane-update slice shared by every stage of the round.
// Ports:
//   stage     in  stage_e  current stage (selects the update rule)
//   lane      in  3        lane being written (coefficient index, S0 addend)
//   self_val  in  32       current value of the lane being written
//   opa       in  32       additive neighbour operand
//   opb       in  32       subtractive neighbour operand
//   opc       in  32       xor neighbour operand
//   result    out 32       new lane value, arithmetic mod 2**32
module mix_alu
    import mix_pkg::*;
(
    input  stage_e       stage,
    input  logic [2:0]   lane,
    input  logic [W-1:0] self_val,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    input  logic [W-1:0] opc,
    output logic [W-1:0] result
);

    always_comb begin
        result = self_val;
        unique case (stage)
            S0: result = self_val + {29'd0, lane};
            S1: result = self_val + opa;
            S2: result = self_val + opa - opb;
            S3: result = self_val ^ (opc << 16);
            // opa carries o[i+4], opb carries o[i+2]
            S4: result = self_val - (opb >> 17) + (opa >> 12);
            S5: result = self_val + opa - opb;
            S6: result = self_val * COEF_A[lane] + COEF_B[lane];
            S7: result = self_val * COEF_C[lane] + COEF_D[lane];
        endcase
    end

endmodule

// File: rtl/mix_round_sequencer.sv
// Time-multiplexed sequencer for the 8-lane mixing datapath: one lane update per cycle,
// 64 cycles per round, ROUNDS rounds per accepted start.
// Ports:
//   clk              in   1    clock, posedge
//   rst              in   1    asynchronous active-high reset (restores seed, aborts a run)
//   start            in   1    begin ROUNDS rounds; sampled only in IDLE
//   init             in   1    reload seed o[i]=i; sampled only in IDLE, wins over start
//   busy             out  1    high while rounds are executing
//   done             out  1    one-cycle pulse after the last lane update
//   round_cnt_total  out  32   completed rounds since reset (only with MIX_ROUND_CNT_EN)
//   state_out        out  256  register file, lane i at [32*i +: 32]
// Build option: define MIX_ROUND_CNT_EN to add the round_cnt_total counter and port.
module mix_round_sequencer
    import mix_pkg::*;
#(
    parameter int unsigned ROUNDS = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               init,
    output logic               busy,
    output logic               done,
`ifdef MIX_ROUND_CNT_EN
    output logic [31:0]        round_cnt_total,
`endif
    output logic [LANES*W-1:0] state_out
);

    localparam logic [CNT_W-1:0] RoundLast = CNT_W'(ROUNDS - 1);

    fsm_e             fsm_q, fsm_d;
    logic [2:0]       lane_q, lane_d;
    logic [2:0]       stage_q, stage_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic [W-1:0]     regs_q [LANES];

    logic             accept;
    logic             reload;
    logic             running;
    logic             round_end;
    logic             last_write;
    stage_e           stage_cur;
    logic [W-1:0]     opa, opb, opc;
    logic [W-1:0]     alu_res;

    assign running    = (fsm_q == RUN);
    assign round_end  = (stage_q == 3'd7) && (lane_q == 3'd7);
    assign last_write = running && round_end && (round_q == RoundLast);
    assign stage_cur  = stage_e'(stage_q);

    // FSM next state; init has priority over start in IDLE
    always_comb begin
        fsm_d  = fsm_q;
        accept = 1'b0;
        reload = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (init) begin
                    reload = 1'b1;
                end else if (start) begin
                    accept = 1'b1;
                    fsm_d  = RUN;
                end
            end
            RUN:     if (last_write) fsm_d = DONE;
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    assign busy = running;
    assign done = (fsm_q == DONE);

    // Lane/stage/round counters; every start begins at stage 0, lane 0, round 0
    always_comb begin
        lane_d  = lane_q;
        stage_d = stage_q;
        round_d = round_q;
        if (accept) begin
            lane_d  = 3'd0;
            stage_d = 3'd0;
            round_d = '0;
        end else if (running) begin
            lane_d = lane_q + 3'd1;
            if (lane_q == 3'd7) stage_d = stage_q + 3'd1;
            if (round_end) round_d = round_q + 1'b1;
        end
    end

    // Operand mux: neighbour lanes wrap mod 8 through 3-bit index arithmetic
    always_comb begin
        opa = '0;
        opb = '0;
        opc = '0;
        unique case (stage_cur)
            S0: ;
            S1: opa = regs_q[lane_q - 3'd1];
            S2: begin
                opa = regs_q[lane_q + 3'd1];
                opb = regs_q[lane_q + 3'd5];
            end
            S3: opc = regs_q[lane_q + 3'd3];
            S4: begin
                opa = regs_q[lane_q + 3'd4];
                opb = regs_q[lane_q + 3'd2];
            end
            S5: begin
                opa = regs_q[lane_q - 3'd1];
                opb = regs_q[lane_q - 3'd2];
            end
            S6: ;
            S7: ;
        endcase
    end

    mix_alu u_alu (
        .stage    (stage_cur),
        .lane     (lane_q),
        .self_val (regs_q[lane_q]),
        .opa      (opa),
        .opb      (opb),
        .opc      (opc),
        .result   (alu_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            lane_q  <= 3'd0;
            stage_q <= 3'd0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            lane_q  <= lane_d;
            stage_q <= stage_d;
            round_q <= round_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) regs_q[i] <= W'(i);
        end else if (reload) begin
            for (int i = 0; i < LANES; i++) regs_q[i] <= W'(i);
        end else if (running) begin
            regs_q[lane_q] <= alu_res;
        end
    end

    always_comb begin
        state_out = '0;
        for (int i = 0; i < LANES; i++) state_out[i*W +: W] = regs_q[i];
    end

`ifdef MIX_ROUND_CNT_EN
    // Cleared only by rst; init leaves it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_cnt_total <= 32'd0;
        end else if (running && round_end) begin
            round_cnt_total <= round_cnt_total + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mix_round_sequencer.sv
module tb_mix_round_sequencer;

    typedef int unsigned lanes_t [8];

    localparam int unsigned CA [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
    localparam int unsigned CB [8] = '{3, 5, 7, 11, 13, 17, 19, 23};
    localparam int unsigned CC [8] = '{2, 3, 3, 3, 5, 13, 35, 87};
    localparam int unsigned CD [8] = '{0, 1, 8, 27, 64, 125, 216, 343};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         init = 1'b0;
    logic         start2 = 1'b0;
    logic         busy, done, busy2, done2;
    logic [255:0] state_out, state_out2;
`ifdef MIX_ROUND_CNT_EN
    logic [31:0]  rcnt, rcnt2;
`endif

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    bit           chk_en = 1'b0;
    int unsigned  done_cnt = 0;

    always #5 clk = ~clk;

    mix_round_sequencer #(.ROUNDS(1), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .init            (init),
        .busy            (busy),
        .done            (done),
`ifdef MIX_ROUND_CNT_EN
        .round_cnt_total (rcnt),
`endif
        .state_out       (state_out)
    );

    mix_round_sequencer #(.ROUNDS(3), .CNT_W(16)) dut3 (
        .clk             (clk),
        .rst             (rst),
        .start           (start2),
        .init            (1'b0),
        .busy            (busy2),
        .done            (done2),
`ifdef MIX_ROUND_CNT_EN
        .round_cnt_total (rcnt2),
`endif
        .state_out       (state_out2)
    );

    // ---------------- reference model ----------------
    function automatic int unsigned mix_f(input lanes_t o, input int unsigned st,
                                          input int unsigned i);
        int unsigned x;
        x = o[i];
        case (st)
            0: return x + i;
            1: return x + o[(i + 7) % 8];
            2: return x + o[(i + 1) % 8] - o[(i + 5) % 8];
            3: return x ^ (o[(i + 3) % 8] << 16);
            4: return x - (o[(i + 2) % 8] >> 17) + (o[(i + 4) % 8] >> 12);
            5: return x + o[(i + 7) % 8] - o[(i + 6) % 8];
            6: return x * CA[i] + CB[i];
            default: return x * CC[i] + CD[i];
        endcase
    endfunction

    function automatic logic [255:0] pack(input lanes_t o);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = o[i];
        return v;
    endfunction

    function automatic logic [255:0] golden(input int unsigned rounds);
        lanes_t o;
        for (int i = 0; i < 8; i++) o[i] = i;
        for (int r = 0; r < int'(rounds); r++)
            for (int st = 0; st < 8; st++)
                for (int i = 0; i < 8; i++) o[i] = mix_f(o, st, i);
        return pack(o);
    endfunction

    // Cycle model of the single-round DUT: lanes, writes still pending, write index, done flag
    lanes_t       m_lanes;
    int unsigned  m_pending = 0;
    int unsigned  m_k = 0;
    bit           m_done = 1'b0;
`ifdef MIX_ROUND_CNT_EN
    int unsigned  m_rounds = 0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_lanes[i] <= i;
            m_pending <= 0;
            m_k       <= 0;
            m_done    <= 1'b0;
`ifdef MIX_ROUND_CNT_EN
            m_rounds  <= 0;
`endif
        end else begin
            m_done <= 1'b0;
            if (m_pending != 0) begin
                m_lanes[m_k % 8] <= mix_f(m_lanes, (m_k / 8) % 8, m_k % 8);
                m_k       <= m_k + 1;
                m_pending <= m_pending - 1;
                if (m_pending == 1) m_done <= 1'b1;
`ifdef MIX_ROUND_CNT_EN
                if (m_k % 64 == 63) m_rounds <= m_rounds + 1;
`endif
            end else if (!m_done) begin
                if (init) begin
                    for (int i = 0; i < 8; i++) m_lanes[i] <= i;
                end else if (start) begin
                    m_pending <= 64;
                    m_k       <= 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_state", state_out, pack(m_lanes));
            check("cyc_busy", {255'd0, busy}, {255'd0, m_pending != 0});
            check("cyc_done", {255'd0, done}, {255'd0, m_done});
`ifdef MIX_ROUND_CNT_EN
            check("cyc_rcnt", {224'd0, rcnt}, {224'd0, m_rounds});
`endif
        end
        if (done) done_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        start  = 1'b0;
    endtask

    // Counts negedges after the acceptance edge until done is seen; optional start poke
    task automatic wait_done(input bit sel, input int unsigned limit, input int unsigned poke,
                             output int unsigned cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (poke != 0 && cyc == poke) start = 1'b1;
            if (poke != 0 && cyc == poke + 1) start = 1'b0;
            if (sel ? done2 : done) seen = 1'b1;
        end
        check("done_seen", {255'd0, seen}, {255'd1});
    endtask

    lanes_t       seed_l, l8, l16;
    int unsigned  cyc, cnt0;

    initial begin
        seed_l = '{0, 1, 2, 3, 4, 5, 6, 7};
        l8     = '{0, 2, 4, 6, 8, 10, 12, 14};
        l16    = '{14, 16, 20, 26, 34, 44, 56, 70};

        // 1: reset state
        #2 rst = 1'b1;
        #10;
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_state", state_out, pack(seed_l));
        check("rst_busy", {255'd0, busy}, 256'd0);
        check("rst_done", {255'd0, done}, 256'd0);

        // 2/3: one round from the seed
        cnt0 = done_cnt;
        pulse_start(1'b0);
        repeat (8) @(negedge clk);
        check("after8", state_out, pack(l8));
        check("busy_run", {255'd0, busy}, 256'd1);
        repeat (8) @(negedge clk);
        check("after16", state_out, pack(l16));
        wait_done(1'b0, 100, 0, cyc);
        check("done_latency", 256'(cyc + 16), 256'd64);
        check("round1", state_out, golden(1));
        repeat (3) @(negedge clk);
        check("done_once", 256'(done_cnt - cnt0), 256'd1);

        // 4: start during RUN and init during DONE are ignored; init+start in IDLE reloads
        pulse_start(1'b0);
        wait_done(1'b0, 100, 10, cyc);
        check("ignored_start_latency", 256'(cyc), 256'd64);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        check("init_in_done_ignored", state_out, golden(2));
        @(negedge clk);
        init  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        init  = 1'b0;
        start = 1'b0;
        check("init_wins", state_out, pack(seed_l));
        check("init_wins_busy", {255'd0, busy}, 256'd0);
        @(negedge clk);
        check("init_wins_busy2", {255'd0, busy}, 256'd0);

        // 5: asynchronous reset mid-round
        pulse_start(1'b0);
        repeat (30) @(negedge clk);
        cnt0 = done_cnt;
        #1 rst = 1'b1;
        #1;
        check("async_rst_state", state_out, pack(seed_l));
        check("async_rst_busy", {255'd0, busy}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (70) @(negedge clk);
        check("no_done_after_abort", 256'(done_cnt - cnt0), 256'd0);
        pulse_start(1'b0);
        wait_done(1'b0, 100, 0, cyc);
        check("fresh_latency", 256'(cyc), 256'd64);
        check("fresh_round", state_out, golden(1));

        // 6: ROUNDS=3 instance, two starts = six rounds
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulse_start(1'b1);
        wait_done(1'b1, 400, 0, cyc);
        check("r3_latency", 256'(cyc), 256'd192);
        check("r3_state", state_out2, golden(3));
        pulse_start(1'b1);
        wait_done(1'b1, 400, 0, cyc);
        check("r3_latency2", 256'(cyc), 256'd192);
        check("r6_state", state_out2, golden(6));
`ifdef MIX_ROUND_CNT_EN
        check("r6_count", {224'd0, rcnt2}, 256'd6);
`endif
        @(negedge clk);
        check("r3_idle", {255'd0, busy2}, 256'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
